// File: rtl/viterbi_pkg.sv
// Shared helpers for the Viterbi path-metric unit: state count, metric
// constants and trellis predecessor mapping.
package viterbi_pkg;

   // Number of trellis states for constraint length k.
   function automatic int unsigned ns(input int unsigned k);
      return 32'd1 << (k - 32'd1);
   endfunction

   // Saturation / "unreachable" metric value for an mw-bit metric.
   function automatic int unsigned inf_of(input int unsigned mw);
      return (32'd1 << mw) - 32'd1;
   endfunction

   // Normalisation step: half of the metric range.
   function automatic int unsigned half_of(input int unsigned mw);
      return 32'd1 << (mw - 32'd1);
   endfunction

   // Predecessor b of state s: {s[K-3:0], b}.
   function automatic int unsigned pred(input int unsigned s,
                                        input int unsigned b,
                                        input int unsigned k);
      return ((s << 1) & (ns(k) - 32'd1)) | (b & 32'd1);
   endfunction

endpackage

// File: rtl/viterbi_pmu_acs_unit.sv
// Saturating two-input add-compare-select cell. Ties select predecessor 0.
module acs_unit
   import viterbi_pkg::*;
#(
   parameter int unsigned MW  = 6,
   parameter int unsigned BMW = 2
) (
   input  logic [MW-1:0]  i_pm0,
   input  logic [MW-1:0]  i_pm1,
   input  logic [BMW-1:0] i_bm0,
   input  logic [BMW-1:0] i_bm1,
   output logic [MW-1:0]  o_metric,
   output logic           o_dec
);

   localparam logic [MW-1:0] INF   = MW'(inf_of(MW));
   localparam logic [MW:0]   INF_W = {1'b0, INF};

   logic [MW:0]   w_sum0;
   logic [MW:0]   w_sum1;
   logic [MW-1:0] w_c0;
   logic [MW-1:0] w_c1;

   // Widened add, saturate to INF, then compare and select.
   always_comb begin
      w_sum0   = {1'b0, i_pm0} + {{(MW + 1 - BMW){1'b0}}, i_bm0};
      w_sum1   = {1'b0, i_pm1} + {{(MW + 1 - BMW){1'b0}}, i_bm1};
      w_c0     = ((i_pm0 == INF) || (w_sum0 >= INF_W)) ? INF : w_sum0[MW-1:0];
      w_c1     = ((i_pm1 == INF) || (w_sum1 >= INF_W)) ? INF : w_sum1[MW-1:0];
      o_dec    = (w_c1 < w_c0);
      o_metric = o_dec ? w_c1 : w_c0;
   end

endmodule

// File: rtl/viterbi_pmu.sv
// Path-metric unit: parallel ACS over all trellis states, metric registers,
// start-of-frame initialisation, normalisation and best-state tracking.
module viterbi_pmu
   import viterbi_pkg::*;
#(
   parameter int unsigned K   = 3,
   parameter int unsigned MW  = 6,
   parameter int unsigned BMW = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic                       in_valid_i,
   input  logic [2*ns(K)*BMW-1:0]     bm_i,
   output logic                       out_valid_o,
   output logic [ns(K)-1:0]           dec_o,
   output logic [ns(K)*MW-1:0]        pm_o,
   output logic [K-2:0]               best_o,
   output logic                       norm_o
);

   localparam int unsigned   NS   = ns(K);
   localparam int unsigned   SW   = K - 1;
   localparam logic [MW-1:0] INF  = MW'(inf_of(MW));
   localparam logic [MW-1:0] HALF = MW'(half_of(MW));

   logic [NS-1:0][MW-1:0] r_pm;
   logic [NS-1:0]         r_dec;
   logic [SW-1:0]         r_best;
   logic                  r_norm;
   logic                  r_out_valid;

   logic [NS-1:0][MW-1:0] w_init;
   logic [NS-1:0][MW-1:0] w_old;
   logic [NS-1:0][MW-1:0] w_new;
   logic [NS-1:0][MW-1:0] w_nrm;
   logic [NS-1:0]         w_dec;
   logic [MW-1:0]         w_min;
   logic [SW-1:0]         w_arg;
   logic                  w_norm;

   // Initial metrics and the old-metric mux (start overrides the registers).
   always_comb begin
      for (int unsigned s = 0; s < NS; s++) begin
         w_init[s] = (s == 0) ? '0 : INF;
         w_old[s]  = start_i ? w_init[s] : r_pm[s];
      end
   end

   for (genvar g = 0; g < NS; g++) begin : g_acs
      localparam int unsigned P0 = pred(g, 0, K);
      localparam int unsigned P1 = pred(g, 1, K);

      acs_unit #(
         .MW  (MW),
         .BMW (BMW)
      ) u_acs (
         .i_pm0    (w_old[P0]),
         .i_pm1    (w_old[P1]),
         .i_bm0    (bm_i[(2*g)*BMW +: BMW]),
         .i_bm1    (bm_i[(2*g+1)*BMW +: BMW]),
         .o_metric (w_new[g]),
         .o_dec    (w_dec[g])
      );
   end

   // Min/argmin over the new metrics; the argmin is taken before the
   // subtraction because normalisation preserves ordering (INF stays largest).
   always_comb begin
      w_min = w_new[0];
      w_arg = '0;
      for (int unsigned s = 1; s < NS; s++) begin
         if (w_new[s] < w_min) begin
            w_min = w_new[s];
            w_arg = SW'(s);
         end
      end
   end

   // Normaliser: shift finite metrics down by HALF once the minimum is high.
   always_comb begin
      w_norm = (w_min >= HALF);
      for (int unsigned s = 0; s < NS; s++) begin
         w_nrm[s] = (w_norm && (w_new[s] != INF)) ? (w_new[s] - HALF) : w_new[s];
      end
   end

   // Metric and output registers; start without a step only reloads metrics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pm        <= w_init;
         r_dec       <= '0;
         r_best      <= '0;
         r_norm      <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (in_valid_i) begin
         r_pm        <= w_nrm;
         r_dec       <= w_dec;
         r_best      <= w_arg;
         r_norm      <= w_norm;
         r_out_valid <= 1'b1;
      end else begin
         r_out_valid <= 1'b0;
         if (start_i) begin
            r_pm <= w_init;
         end
      end
   end

   assign pm_o        = r_pm;
   assign dec_o       = r_dec;
   assign best_o      = r_best;
   assign norm_o      = r_norm;
   assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_viterbi_pmu.sv
// Self-checking bench for viterbi_pmu (K=3, MW=6, BMW=2): a behavioural model
// pushes expected results per accepted step; a monitor pops them on out_valid_o.
module tb_viterbi_pmu;

   localparam int K   = 3;
   localparam int MW  = 6;
   localparam int BMW = 2;
   localparam int NS  = 4;

   typedef struct packed {
      logic [23:0] pm;
      logic [3:0]  dec;
      logic [1:0]  best;
      logic        norm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic [15:0] bm_i = '0;
   logic        out_valid_o;
   logic [3:0]  dec_o;
   logic [23:0] pm_o;
   logic [1:0]  best_o;
   logic        norm_o;

   int   total = 0;
   int   bad   = 0;
   int   m_pm[NS];
   exp_t q[$];
   exp_t mon_e;

   viterbi_pmu #(
      .K   (K),
      .MW  (MW),
      .BMW (BMW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .in_valid_i  (in_valid_i),
      .bm_i        (bm_i),
      .out_valid_o (out_valid_o),
      .dec_o       (dec_o),
      .pm_o        (pm_o),
      .best_o      (best_o),
      .norm_o      (norm_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bm_all(input logic [1:0] b0, input logic [1:0] b1);
      logic [15:0] v;
      v = '0;
      for (int s = 0; s < NS; s++) begin
         v[4*s +: 2]     = b0;
         v[4*s + 2 +: 2] = b1;
      end
      return v;
   endfunction

   function automatic int cand(input int pm, input int b);
      if (pm == 63 || pm + b >= 63) return 63;
      return pm + b;
   endfunction

   function automatic logic [23:0] pack4(input int a0, input int a1, input int a2, input int a3);
      return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
   endfunction

   task automatic model_reset();
      m_pm[0] = 0;
      for (int s = 1; s < NS; s++) m_pm[s] = 63;
   endtask

   task automatic model_step(input logic st, input logic [15:0] bm);
      int   old[NS];
      int   nw[NS];
      int   p0, c0, c1, mn;
      exp_t e;
      e = '0;
      for (int s = 0; s < NS; s++) old[s] = st ? ((s == 0) ? 0 : 63) : m_pm[s];
      for (int s = 0; s < NS; s++) begin
         p0 = (s % 2) * 2;
         c0 = cand(old[p0], int'(bm[4*s +: 2]));
         c1 = cand(old[p0 + 1], int'(bm[4*s + 2 +: 2]));
         if (c0 <= c1) begin
            nw[s] = c0;
            e.dec[s] = 1'b0;
         end else begin
            nw[s] = c1;
            e.dec[s] = 1'b1;
         end
      end
      mn = nw[0];
      e.best = 2'd0;
      for (int s = 1; s < NS; s++) begin
         if (nw[s] < mn) begin
            mn = nw[s];
            e.best = 2'(s);
         end
      end
      e.norm = (mn >= 32);
      if (e.norm) begin
         for (int s = 0; s < NS; s++) if (nw[s] != 63) nw[s] = nw[s] - 32;
      end
      e.pm = pack4(nw[0], nw[1], nw[2], nw[3]);
      for (int s = 0; s < NS; s++) m_pm[s] = nw[s];
      q.push_back(e);
   endtask

   // One cycle of stimulus, applied on the falling edge.
   task automatic drive(input logic st, input logic v, input logic [15:0] bm);
      @(negedge clk);
      start_i    = st;
      in_valid_i = v;
      bm_i       = bm;
      if (v) model_step(st, bm);
      else if (st) model_reset();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0);
   endtask

   // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1 && out_valid_o !== 1'b0) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious_valid: out_valid_o=%b with no step pending", out_valid_o);
         end else begin
            mon_e = q.pop_front();
            total++;
            if (pm_o !== mon_e.pm) begin
               bad++;
               $display("FAIL sb_pm: got %h expected %h", pm_o, mon_e.pm);
            end
            total++;
            if (dec_o !== mon_e.dec) begin
               bad++;
               $display("FAIL sb_dec: got %b expected %b", dec_o, mon_e.dec);
            end
            total++;
            if (best_o !== mon_e.best) begin
               bad++;
               $display("FAIL sb_best: got %0d expected %0d", best_o, mon_e.best);
            end
            total++;
            if (norm_o !== mon_e.norm) begin
               bad++;
               $display("FAIL sb_norm: got %b expected %b", norm_o, mon_e.norm);
            end
         end
      end
   end

   task automatic test_drained(input string name);
      idle(1);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_drained: %0d outputs missing, expected 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12;
      total++;
      if (pm_o !== pack4(0, 63, 63, 63)) begin
         bad++;
         $display("FAIL reset_pm: got %h expected %h", pm_o, pack4(0, 63, 63, 63));
      end
      total++;
      if (out_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b expected 0", out_valid_o);
      end
      total++;
      if (best_o !== 2'd0 || dec_o !== 4'd0 || norm_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs: best=%0d dec=%b norm=%b expected 0/0000/0", best_o, dec_o, norm_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_first_step();
      drive(1'b1, 1'b1, bm_all(2'd1, 2'd2));
      idle(1);
      total++;
      if (pm_o !== pack4(1, 63, 1, 63) || dec_o !== 4'b0000 || out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL first_step: pm=%h dec=%b vld=%b expected %h 0000 1",
                  pm_o, dec_o, out_valid_o, pack4(1, 63, 1, 63));
      end
      idle(1);
      total++;
      if (out_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL first_pulse: out_valid_o=%b expected 0 one cycle later", out_valid_o);
      end
      test_drained("first_step");
   endtask

   task automatic test_tie_sat();
      drive(1'b0, 1'b1, bm_all(2'd0, 2'd0));
      drive(1'b0, 1'b1, bm_all(2'd3, 2'd3));
      idle(1);
      total++;
      if (dec_o !== 4'b0000 || pm_o !== pack4(4, 4, 4, 4)) begin
         bad++;
         $display("FAIL tie: dec=%b pm=%h expected 0000 %h", dec_o, pm_o, pack4(4, 4, 4, 4));
      end
      // INF plus a non-zero branch metric must stay INF, never wrap.
      drive(1'b1, 1'b1, bm_all(2'd3, 2'd3));
      drive(1'b0, 1'b1, bm_all(2'd3, 2'd3));
      idle(1);
      total++;
      if (pm_o !== pack4(6, 6, 6, 6)) begin
         bad++;
         $display("FAIL sat_step2: pm=%h expected %h", pm_o, pack4(6, 6, 6, 6));
      end
      drive(1'b1, 1'b1, bm_all(2'd3, 2'd3));
      idle(1);
      total++;
      if (pm_o !== pack4(3, 63, 3, 63)) begin
         bad++;
         $display("FAIL saturate: pm=%h expected %h", pm_o, pack4(3, 63, 3, 63));
      end
      test_drained("tie_sat");
   endtask

   task automatic test_normalise();
      drive(1'b1, 1'b1, bm_all(2'd0, 2'd0));
      drive(1'b0, 1'b1, bm_all(2'd0, 2'd0));
      for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, bm_all(2'd3, 2'd3));
      idle(1);
      total++;
      if (norm_o !== 1'b1 || pm_o !== pack4(1, 1, 1, 1)) begin
         bad++;
         $display("FAIL normalise: norm=%b pm=%h expected 1 %h", norm_o, pm_o, pack4(1, 1, 1, 1));
      end
      drive(1'b0, 1'b1, bm_all(2'd1, 2'd1));
      idle(1);
      total++;
      if (norm_o !== 1'b0) begin
         bad++;
         $display("FAIL norm_clear: norm=%b expected 0", norm_o);
      end
      test_drained("normalise");
   endtask

   task automatic test_stall_restart();
      logic [23:0] snap;
      drive(1'b0, 1'b1, bm_all(2'd2, 2'd1));
      idle(1);
      snap = pack4(m_pm[0], m_pm[1], m_pm[2], m_pm[3]);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         total++;
         if (pm_o !== snap || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: pm=%h vld=%b expected %h 0", pm_o, out_valid_o, snap);
         end
      end
      drive(1'b1, 1'b0, '0);
      idle(2);
      total++;
      if (pm_o !== pack4(0, 63, 63, 63) || out_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL start_only: pm=%h vld=%b expected %h 0", pm_o, out_valid_o, pack4(0, 63, 63, 63));
      end
      test_drained("stall_restart");
   endtask

   task automatic test_back_to_back();
      int r;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) drive((r == 0), 1'b1, 16'($urandom));
         else if (r < 9) idle(1);
         else drive(1'b1, 1'b0, '0);
      end
      test_drained("back_to_back");
   endtask

   task automatic test_reset_midframe();
      drive(1'b1, 1'b1, bm_all(2'd1, 2'd1));
      idle(1);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (pm_o !== pack4(0, 63, 63, 63) || out_valid_o !== 1'b0 || best_o !== 2'd0 || dec_o !== 4'd0) begin
         bad++;
         $display("FAIL async_reset: pm=%h vld=%b best=%0d dec=%b expected %h 0 0 0000",
                  pm_o, out_valid_o, best_o, dec_o, pack4(0, 63, 63, 63));
      end
      q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, bm_all(2'd2, 2'd0));
      test_drained("reset_midframe");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_step();
      test_tie_sat();
      test_normalise();
      test_stall_restart();
      test_back_to_back();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
